// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: step timer plus chase/bounce/blink/count pattern engine.
// Mode and step period load over a valid/ready handshake while idle; start/stop/pause control the run.
module led_pattern_ctrl #(
  parameter int unsigned WIDTH         = 25,
  parameter int unsigned DEFAULT_LIMIT = 250_000,
  parameter int unsigned N_LEDS        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [WIDTH-1:0]  cfg_limit,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [N_LEDS-1:0] leds,
  output logic              step,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [1:0]        MODE_CHASE  = 2'b00;
  localparam logic [1:0]        MODE_BOUNCE = 2'b01;
  localparam logic [1:0]        MODE_BLINK  = 2'b10;
  localparam logic [1:0]        MODE_COUNT  = 2'b11;
  localparam logic [WIDTH-1:0]  RESET_LIMIT = WIDTH'(DEFAULT_LIMIT);
  localparam logic [WIDTH-1:0]  ONE         = WIDTH'(1);
  localparam logic [N_LEDS-1:0] FIRST_LED   = N_LEDS'(1);

  state_t            state;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  cnt;
  logic              dir_down;

  logic              cfg_hs;
  logic [1:0]        run_mode;
  logic [WIDTH-1:0]  cfg_limit_fix;
  logic              at_limit;
  logic [N_LEDS-1:0] init_leds;
  logic [N_LEDS-1:0] up_leds;
  logic [N_LEDS-1:0] down_leds;
  logic [N_LEDS-1:0] next_leds;
  logic              next_dir_down;

  assign cfg_ready     = (state == IDLE);
  assign cfg_hs        = cfg_valid & cfg_ready;
  // A handshake coinciding with start takes effect for the run it launches.
  assign run_mode      = cfg_hs ? cfg_mode : mode;
  assign cfg_limit_fix = (cfg_limit == '0) ? ONE : cfg_limit;
  assign at_limit      = (cnt == (limit - ONE));
  assign init_leds     = ((run_mode == MODE_CHASE) || (run_mode == MODE_BOUNCE)) ? FIRST_LED : '0;
  assign up_leds       = {leds[N_LEDS-2:0], 1'b0};
  assign down_leds     = {1'b0, leds[N_LEDS-1:1]};

  // Pattern value and bounce direction after one advance.
  always_comb begin
    next_leds     = leds;
    next_dir_down = dir_down;
    case (mode)
      MODE_CHASE: next_leds = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
      MODE_BOUNCE: begin
        if (!dir_down) begin
          next_leds = up_leds;
          if (up_leds[N_LEDS-1]) next_dir_down = 1'b1;
        end else begin
          next_leds = down_leds;
          if (down_leds[0]) next_dir_down = 1'b0;
        end
      end
      MODE_BLINK: next_leds = ~leds;
      MODE_COUNT: next_leds = leds + N_LEDS'(1);
      default:    next_leds = leds;
    endcase
  end

  // Control FSM, step timer and LED register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode     <= MODE_CHASE;
      limit    <= RESET_LIMIT;
      cnt      <= '0;
      dir_down <= 1'b0;
      leds     <= '0;
      step     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      step <= 1'b0;
      if (cfg_hs) begin
        mode  <= cfg_mode;
        limit <= cfg_limit_fix;
      end
      case (state)
        IDLE: begin
          if (stop) begin
            leds <= '0;
            cnt  <= '0;
          end else if (start && !pause) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            dir_down <= 1'b0;
            leds     <= init_leds;
          end
        end
        RUN, PAUSE: begin
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            dir_down <= 1'b0;
            leds     <= '0;
          end else if (pause) begin
            state <= PAUSE;
          end else begin
            // Releasing pause resumes counting on the same cycle.
            state <= RUN;
            if (at_limit) begin
              cnt      <= '0;
              leds     <= next_leds;
              dir_down <= next_dir_down;
              step     <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
          leds  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: vector table of pattern runs plus hand-written
// sequences; expected step times/values are queued at stimulus time and matched on each step pulse.
module tb_led_pattern_ctrl;

  localparam int unsigned WIDTH  = 25;
  localparam int unsigned DEFLIM = 40;
  localparam int unsigned NL     = 4;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] cfg_limit;
  logic             start;
  logic             stop;
  logic             pause;
  logic [NL-1:0]    leds;
  logic             step;
  logic             busy;

  led_pattern_ctrl #(.WIDTH(WIDTH), .DEFAULT_LIMIT(DEFLIM), .N_LEDS(NL)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_limit(cfg_limit), .start(start), .stop(stop),
    .pause(pause), .leds(leds), .step(step), .busy(busy)
  );

  typedef struct {
    int unsigned   cyc;
    logic [NL-1:0] val;
  } exp_t;

  typedef struct packed {
    logic [1:0]        mode;
    logic [WIDTH-1:0]  limit;
    logic [NL-1:0]     init;
    logic [15:0][3:0]  seq;
  } vec_t;

  localparam int NV = 6;
  vec_t        vt [NV];
  exp_t        sb [$];
  int unsigned cyc;
  int unsigned c0;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Step monitor: each pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (step === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step actual=step leds=%b required=no step (cyc %0d)", leds, cyc);
      end else begin
        e = sb.pop_front();
        chk("step_cycle", 32'(cyc), 32'(e.cyc));
        chk("step_leds", 32'(leds), 32'(e.val));
      end
    end
  end

  task automatic push(input int unsigned c, input logic [NL-1:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic configure(input logic [1:0] m, input logic [WIDTH-1:0] l);
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_limit = l;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic start_run(input logic [NL-1:0] init);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    chk("start_leds", 32'(leds), 32'(init));
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_step", 32'(step), 32'd0);
  endtask

  task automatic stop_run();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_leds", 32'(leds), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_ready", 32'(cfg_ready), 32'd1);
    chk("stop_step", 32'(step), 32'd0);
  endtask

  initial begin
    int unsigned lim;
    int n;
    vt[0] = '{2'b00, 25'd3, 4'b0001, 64'h1842_1842_1842_1842};
    vt[1] = '{2'b01, 25'd3, 4'b0001, 64'h4842_1248_4212_4842};
    vt[2] = '{2'b10, 25'd3, 4'b0000, 64'h0F0F_0F0F_0F0F_0F0F};
    vt[3] = '{2'b11, 25'd0, 4'b0000, 64'h0FED_CBA9_8765_4321};
    vt[4] = '{2'b11, 25'd3, 4'b0000, 64'h0FED_CBA9_8765_4321};
    vt[5] = '{2'b00, 25'd1, 4'b0001, 64'h1842_1842_1842_1842};

    checks = 0; failures = 0; cyc = 0; c0 = 0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_limit = '0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);

    // Default configuration: chase at the reset step period.
    start_run(4'b0001);
    push(c0 + DEFLIM, 4'b0010);
    drain(DEFLIM + 20);
    stop_run();

    for (int i = 0; i < NV; i++) begin
      configure(vt[i].mode, vt[i].limit);
      start_run(vt[i].init);
      lim = (vt[i].limit == '0) ? 1 : int'(vt[i].limit);
      for (int k = 0; k < 16; k++) push(c0 + (k + 1) * lim, vt[i].seq[k]);
      drain(16 * lim + 20);
      stop_run();
    end

    // Pause mid-period for 5 cycles: second step slips by exactly 5 cycles.
    configure(2'b00, 25'd3);
    start_run(4'b0001);
    push(c0 + 3, 4'b0010);
    push(c0 + 6 + 5, 4'b0100);
    n = 0;
    while (sb.size() > 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("pause_first_step", 32'(sb.size()), 32'd1);
    @(negedge clk);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("pause_leds", 32'(leds), 32'b0010);
      chk("pause_busy", 32'(busy), 32'd1);
    end
    pause = 1'b0;
    drain(20);
    pause = 1'b1;
    stop_run();
    pause = 1'b0;

    // Config offered while busy and a stray start: both ignored.
    start_run(4'b0001);
    cfg_valid = 1'b1; cfg_mode = 2'b01; cfg_limit = 25'd5; start = 1'b1;
    push(c0 + 3, 4'b0010);
    push(c0 + 6, 4'b0100);
    push(c0 + 9, 4'b1000);
    push(c0 + 12, 4'b0001);
    @(negedge clk);
    chk("busy_cfg_ready", 32'(cfg_ready), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("busy_cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    drain(30);
    stop_run();
    start_run(4'b0001);
    push(c0 + 3, 4'b0010);
    drain(20);
    stop_run();

    // Handshake and start together: bounce at period 2 for this very run.
    cfg_valid = 1'b1; cfg_mode = 2'b01; cfg_limit = 25'd2; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    c0 = cyc;
    chk("bypass_leds", 32'(leds), 32'b0001);
    chk("bypass_busy", 32'(busy), 32'd1);
    push(c0 + 2, 4'b0010);
    push(c0 + 4, 4'b0100);
    push(c0 + 6, 4'b1000);
    push(c0 + 8, 4'b0100);
    drain(20);

    // Reset mid-run restores default mode and period.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_leds", 32'(leds), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    chk("midrst_step", 32'(step), 32'd0);
    start_run(4'b0001);
    push(c0 + DEFLIM, 4'b0010);
    push(c0 + 2 * DEFLIM, 4'b0100);
    push(c0 + 3 * DEFLIM, 4'b1000);
    push(c0 + 4 * DEFLIM, 4'b0001);
    drain(4 * DEFLIM + 20);
    stop_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
